// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: fetch and MEM-stage data share one bus port.
// Data has priority; a streak counter guarantees fetch a grant after DATA_STREAK_MAX data grants.
module mem_bus_arbiter #(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    input  logic        inst_cached,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    input  logic        flush,
    input  logic        data_ren,
    input  logic        data_wen,
    input  logic [3:0]  data_wsel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_cached,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        data_bvalid,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wsel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_cached,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    localparam int SW = $clog2(DATA_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_TOP = SW'(DATA_STREAK_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] streak;
    logic          own_inst;
    logic          own_wr;
    logic          flush_pend;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wsel_q;
    logic          cached_q;
    logic          data_any;
    logic          grant_inst;
    logic          grant_data;
    logic          grant;
    logic          take_wr;

    always_comb begin
        data_any   = data_ren | data_wen;
        grant_inst = inst_ren && (!data_any || streak == STREAK_TOP);
        grant_data = data_any && !grant_inst;
        grant      = grant_inst || grant_data;
        // A simultaneous load and store request is issued as the store.
        take_wr    = grant_data && data_wen;
    end

    always_comb begin
        state_nxt   = state;
        bus_req     = 1'b0;
        bus_wr      = 1'b0;
        bus_wsel    = '0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_cached  = 1'b0;
        inst_rvalid = 1'b0;
        data_rvalid = 1'b0;
        data_bvalid = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) state_nxt = REQ;
            end
            REQ: begin
                bus_req    = 1'b1;
                bus_wr     = own_wr;
                bus_wsel   = wsel_q;
                bus_addr   = addr_q;
                bus_wdata  = wdata_q;
                bus_cached = cached_q;
                if (bus_addr_ok) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus_data_ok) state_nxt = RESP;
            end
            RESP: begin
                state_nxt   = IDLE;
                inst_rvalid = own_inst && !flush_pend && !flush;
                data_rvalid = !own_inst && !own_wr;
                data_bvalid = !own_inst && own_wr;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            streak     <= '0;
            own_inst   <= 1'b0;
            own_wr     <= 1'b0;
            flush_pend <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wsel_q     <= '0;
            cached_q   <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant) begin
                own_inst <= grant_inst;
                own_wr   <= take_wr;
                addr_q   <= grant_inst ? inst_addr : data_addr;
                wdata_q  <= take_wr ? data_wdata : '0;
                wsel_q   <= take_wr ? data_wsel : '0;
                cached_q <= grant_inst ? inst_cached : data_cached;
                if (grant_data && inst_ren) begin
                    if (streak != STREAK_TOP) streak <= streak + SW'(1);
                end else begin
                    streak <= '0;
                end
            end
            if ((state == REQ || state == WAIT) && own_inst && flush)
                flush_pend <= 1'b1;
            if (state == WAIT && bus_data_ok && !own_wr) begin
                if (own_inst) inst_rdata <= bus_rdata;
                else          data_rdata <= bus_rdata;
            end
            if (state == RESP) flush_pend <= 1'b0;
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory bus port between two requesters: instruction fetch and the MEM-stage data port (ren/wen/wsel/addr/wdata/cached).
- It serializes transactions, with one outstanding at a time.
- The data port has priority, with a bounded-starvation guard for fetch.
- Responses return as one-cycle rvalid/bvalid pulses, which the MEM stage and fetch stage use to drop their stall requests.

Parameters:
- DATA_STREAK_MAX, 4: maximum consecutive data grants while fetch is waiting. The next grant goes to fetch.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- inst_ren  in  1  fetch read request; held until inst_rvalid
- inst_addr  in  32  fetch address (word aligned)
- inst_cached  in  1  fetch cacheability attribute
- inst_rdata  out  32  fetch read data
- inst_rvalid  out  1  one-cycle fetch completion pulse
- flush  in  1  pipeline flush; discards the in-flight fetch result
- data_ren  in  1  load request; held until data_rvalid
- data_wen  in  1  store request; held until data_bvalid
- data_wsel  in  4  store byte enables
- data_addr  in  32  data address (word aligned)
- data_wdata  in  32  store data
- data_cached  in  1  data cacheability attribute
- data_rdata  out  32  load data
- data_rvalid  out  1  one-cycle load completion pulse
- data_bvalid  out  1  one-cycle store completion pulse
- bus_req  out  1  bus request
- bus_wr  out  1  1 = write
- bus_wsel  out  4  byte enables; 0 on reads
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_cached  out  1  cacheability
- bus_addr_ok  in  1  request accepted this cycle
- bus_data_ok  in  1  read data valid / write done
- bus_rdata  in  32  bus read data

Behaviour:
- States:
  - IDLE: arbitrate.
  - REQ: bus_req=1, address/data stable.
  - WAIT: await bus_data_ok.
  - RESP: pulse the response.
- Reset, and every output in IDLE/WAIT/RESP except as stated:
  - bus_req, bus_wr, bus_wsel, bus_addr, bus_wdata, bus_cached, all valid pulses = 0.
  - inst_rdata and data_rdata = 0.
  - State = IDLE, streak counter = 0, flush_pend = 0.
- Arbitration in IDLE, when any request is present:
  - Grant data if data_ren|data_wen is high, unless inst_ren=1 and the streak counter equals DATA_STREAK_MAX. In that case grant inst.
  - The granted request's addr/wdata/wsel/cached/type are latched into the bus_* registers. Next state = REQ.
- Streak counter:
  - Increments on a data grant while inst_ren=1.
  - Clears on any inst grant, or on a data grant with inst_ren=0.
  - Saturates at DATA_STREAK_MAX.
- data_wen && data_ren both high: treated as a write.
- REQ: bus_req is held with stable payload until bus_addr_ok=1, then goes to WAIT. bus_data_ok in REQ is ignored; the bus never returns data_ok in the addr_ok cycle.
- WAIT: on bus_data_ok=1, capture bus_rdata into inst_rdata or data_rdata (reads only), then go to RESP.
- RESP: one-cycle pulse, then IDLE.
  - data read: data_rvalid=1.
  - data write: data_bvalid=1.
  - inst read: inst_rvalid=1 unless flush_pend, in which case no pulse.
  - The captured rdata holds until the next capture.
- Latency: a request sampled in IDLE at cycle 0 gives bus_req at cycle 1. With addr_ok at cycle a and data_ok at cycle d>a, the completion pulse is at d+1. Minimum 3 cycles request-to-pulse. The next grant is sampled in the cycle after RESP.
- flush:
  - Sets flush_pend when flush=1 while an inst transaction is in REQ or WAIT. A flush in RESP suppresses that cycle's inst_rvalid.
  - The bus transaction always runs to completion; there is no bus abort.
  - flush_pend clears on leaving RESP.
  - flush in IDLE has no effect. flush never affects data transactions.
- Re-issue: a request still asserted in the cycle after its completion pulse is a new transaction. This is legal, e.g. a pipeline held by another stall.
- Request dropped before grant: ignored. Request dropped after grant: the transaction completes and its pulse is still issued. The requester must tolerate this.
- rst mid-transaction: return to IDLE next edge, with outputs as at reset. The bus shares rst.

Test Plan:
- Single load:
  - Stimulus: data_ren=1, addr=0x0000_1004, cached=1. addr_ok at cycle 2, data_ok at cycle 4 with rdata=0xDEADBEEF.
  - Required: bus_req high cycles 1–2, bus_wr=0, bus_wsel=0. data_rvalid pulses cycle 5 with data_rdata=0xDEADBEEF.
- Store:
  - Stimulus: data_wen=1, wsel=4'b1100, wdata=0x12345678. addr_ok held low 3 cycles.
  - Required: bus payload stable throughout REQ. data_bvalid exactly one cycle after data_ok. inst_rvalid stays 0.
- Simultaneous inst_ren and data_ren at cycle 0:
  - Required: data granted first. inst granted in the IDLE after data RESP, with its own pulse.
- Starvation, DATA_STREAK_MAX=4:
  - Stimulus: data_ren held continuously, inst_ren held.
  - Required: grant order D,D,D,D,I, then the pattern repeats.
- Flush during an inst WAIT:
  - Required: the bus transaction completes, inst_rvalid stays 0. A subsequent fetch returns normally.
- rst asserted during WAIT:
  - Required: next cycle all outputs 0 and state IDLE. A new load after rst completes correctly.
